// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Inter-stage pipeline register carrying a control bundle and a datapath
// bundle between two adjacent core stages, with a valid/ready handshake,
// an optional one-entry skid buffer, a synchronous flush, and a saturating
// stall-cycle counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that link. The sender keeps valid and its payload stable
// until the transfer completes. Ready may be high without valid. On the
// input side, accept = in_valid && in_ready. On the output side,
// fire = out_valid && out_ready.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream holds a valid instruction
//   in_ready   this stage accepts in_ctrl/in_data this cycle
//   in_ctrl    upstream control bundle   [CTRL_W]
//   in_data    upstream datapath bundle  [DATA_W]
//   out_valid  main entry holds a valid instruction
//   out_ready  downstream accepts (low = stall)
//   out_ctrl   control bundle, RESET_CTRL whenever out_valid is low
//   out_data   datapath bundle (don't-care when out_valid is low)
//   flush      synchronous kill of held and incoming entries
//   cnt_clr    synchronous clear of the stall counter
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
//
// Parameters:
//   CTRL_W, DATA_W  bundle widths
//   SKID            1: two entries, in_ready registered; 0: one entry,
//                   in_ready depends combinationally on out_ready
//   RESET_CTRL      control value for bubbles (must be a NOP encoding)
//   CNT_W           stall counter width
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int                 CTRL_W     = 12,
  parameter int                 DATA_W     = 144,
  parameter int                 SKID       = 1,
  parameter logic [CTRL_W-1:0]  RESET_CTRL = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {skid_v, main_v}, so the occupancy bits read straight
  // out of the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic main_v;
  logic accept;
  logic fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  assign main_v = (state_q != ST_EMPTY);
  assign accept = in_valid && in_ready;
  assign fire   = main_v && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Ready only looks at whether the skid slot is free, so it is a
      // pure register output and never depends on out_ready.
      assign in_ready = (state_q != ST_TWO);
    end else begin : g_noskid
      assign in_ready = !main_v || out_ready;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and load selects
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          load_main_in = 1'b1;
        end else if (accept && !fire) begin
          // Only reachable with the skid slot present: without it,
          // in_ready already requires out_ready while main is full.
          if (SKID != 0) begin
            state_d      = ST_TWO;
            load_skid_in = 1'b1;
          end
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (fire) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Flush discards both entries and anything accepted this cycle.
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  // Payload registers. Control is forced to the NOP value on flush so a
  // killed entry can never leak write enables; data is left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= RESET_CTRL;
      main_data <= '0;
      skid_ctrl <= RESET_CTRL;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= RESET_CTRL;
      skid_ctrl <= RESET_CTRL;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid_in) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_ctrl : RESET_CTRL;
  assign out_data  = main_data;

  // Stall counter: clear wins over increment; flush does not gate it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Directed bench for pipe_stage_skid. Two instances share one set of input
// drives: u_skid (SKID=1) and u_noskid (SKID=0), both with CNT_W=4 and a
// nonzero RESET_CTRL. The variable sel picks which instance's outputs the
// source/sink model observes.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int CTRL_W = 12;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam logic [CTRL_W-1:0] RC = 12'h0F0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared inputs
  logic              in_valid  = 1'b0;
  logic [CTRL_W-1:0] in_ctrl   = '0;
  logic [DATA_W-1:0] in_data   = '0;
  logic              out_ready = 1'b0;
  logic              flush     = 1'b0;
  logic              cnt_clr   = 1'b0;

  // per-instance outputs
  logic              s1_in_ready, s0_in_ready;
  logic              s1_out_valid, s0_out_valid;
  logic [CTRL_W-1:0] s1_out_ctrl, s0_out_ctrl;
  logic [DATA_W-1:0] s1_out_data, s0_out_data;
  logic [CNT_W-1:0]  s1_stall_cnt, s0_stall_cnt;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .RESET_CTRL(RC), .CNT_W(CNT_W)
  ) u_skid (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s1_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s1_out_valid), .out_ready(out_ready),
    .out_ctrl(s1_out_ctrl), .out_data(s1_out_data),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(s1_stall_cnt)
  );

  pipe_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .RESET_CTRL(RC), .CNT_W(CNT_W)
  ) u_noskid (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s0_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s0_out_valid), .out_ready(out_ready),
    .out_ctrl(s0_out_ctrl), .out_data(s0_out_data),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(s0_stall_cnt)
  );

  // observed view
  logic sel = 1'b1;
  logic              m_in_ready, m_out_valid;
  logic [CTRL_W-1:0] m_out_ctrl;
  logic [DATA_W-1:0] m_out_data;
  logic [CNT_W-1:0]  m_stall_cnt;
  assign m_in_ready  = sel ? s1_in_ready  : s0_in_ready;
  assign m_out_valid = sel ? s1_out_valid : s0_out_valid;
  assign m_out_ctrl  = sel ? s1_out_ctrl  : s0_out_ctrl;
  assign m_out_data  = sel ? s1_out_data  : s0_out_data;
  assign m_stall_cnt = sel ? s1_stall_cnt : s0_stall_cnt;

  // scoreboard
  logic [CTRL_W-1:0] src_q[$];
  logic [CTRL_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int fired    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present the head of the source queue upstream.
  task automatic drive_src();
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      in_ctrl  = src_q[0];
      in_data  = {4'h1, src_q[0]};
    end else begin
      in_valid = 1'b0;
      in_ctrl  = '0;
      in_data  = '0;
    end
  endtask

  // One clock cycle: record handshakes before the edge, retire after it.
  task automatic tick();
    logic acc;
    logic [CTRL_W-1:0] e;
    #1;
    acc = in_valid && m_in_ready;
    if (m_out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_fire", {31'd0, m_out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("order_ctrl", {20'd0, m_out_ctrl}, {20'd0, e});
        check("order_data", {16'd0, m_out_data}, {16'd0, 4'h1, e});
        fired++;
      end
    end
    @(posedge clk);
    #1;
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    drive_src();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    fired     = 0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    drive_src();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_stream(input int n);
    for (int i = 1; i <= n; i++) begin
      src_q.push_back(CTRL_W'(i));
      exp_q.push_back(CTRL_W'(i));
    end
    drive_src();
  endtask

  initial begin
    // ---------------- reset state (SKID=1)
    sel = 1'b1;
    do_reset();
    check("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, m_in_ready},  32'd1);
    check("rst_out_ctrl",  {20'd0, m_out_ctrl},  {20'd0, RC});
    check("rst_out_data",  {16'd0, m_out_data},  32'd0);
    check("rst_stall_cnt", {28'd0, m_stall_cnt}, 32'd0);

    // ---------------- streaming, SKID=1
    do_reset();
    out_ready = 1'b1;
    load_stream(8);
    repeat (9) tick();
    check("s1_stream_fired", fired, 32'd8);
    check("s1_stream_left",  exp_q.size(), 32'd0);

    // ---------------- skid behaviour, SKID=1
    do_reset();
    out_ready = 1'b1;
    load_stream(3);
    tick();                    // accept 1
    out_ready = 1'b0;
    tick();                    // 1 stalled, 2 into skid
    check("s1_in_ready_low", {31'd0, m_in_ready}, 32'd0);
    check("s1_hold_ctrl",    {20'd0, m_out_ctrl}, 32'd1);
    tick();
    tick();
    check("s1_stall3", {28'd0, m_stall_cnt}, 32'd3);
    out_ready = 1'b1;
    tick();                    // 1 fires, 2 moves to main
    check("s1_in_ready_back", {31'd0, m_in_ready}, 32'd1);
    tick();
    tick();
    check("s1_skid_fired", fired, 32'd3);
    check("s1_skid_left",  exp_q.size(), 32'd0);
    check("s1_skid_cnt",   {28'd0, m_stall_cnt}, 32'd3);

    // ---------------- counter saturation and clear
    do_reset();
    src_q.push_back(12'd5);
    drive_src();
    tick();                    // accept 5, out_ready stays low
    repeat (10) tick();
    check("cnt_10", {28'd0, m_stall_cnt}, 32'd10);
    repeat (10) tick();
    check("cnt_sat", {28'd0, m_stall_cnt}, 32'd15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr", {28'd0, m_stall_cnt}, 32'd0);
    tick();
    check("cnt_resume", {28'd0, m_stall_cnt}, 32'd1);

    // ---------------- flush with TWO occupied and stalled
    do_reset();
    src_q.push_back(12'd1);
    src_q.push_back(12'd2);
    drive_src();
    out_ready = 1'b1;
    tick();                    // accept 1
    out_ready = 1'b0;
    tick();                    // 2 into skid, cnt=1
    src_q.push_back(12'd9);
    drive_src();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("flush_out_ctrl",  {20'd0, m_out_ctrl},  {20'd0, RC});
    check("flush_in_ready",  {31'd0, m_in_ready},  32'd1);
    check("flush_stall_cnt", {28'd0, m_stall_cnt}, 32'd2);
    src_q.delete();
    drive_src();
    out_ready = 1'b1;
    repeat (3) tick();
    check("flush_nothing_out", fired, 32'd0);

    // ---------------- flush in ONE: fire delivered, accepted entry dropped
    do_reset();
    src_q.push_back(12'd4);
    src_q.push_back(12'd9);
    exp_q.push_back(12'd4);
    drive_src();
    out_ready = 1'b1;
    tick();                    // accept 4
    flush = 1'b1;
    tick();                    // 4 fires, 9 accepted then discarded
    flush = 1'b0;
    check("flush1_out_valid", {31'd0, m_out_valid}, 32'd0);
    repeat (2) tick();
    check("flush1_fired", fired, 32'd1);

    // ---------------- asynchronous reset mid-cycle with TWO occupied
    do_reset();
    src_q.push_back(12'd1);
    src_q.push_back(12'd2);
    drive_src();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();                    // cnt=2
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("arst_in_ready",  {31'd0, m_in_ready},  32'd1);
    check("arst_out_ctrl",  {20'd0, m_out_ctrl},  {20'd0, RC});
    check("arst_out_data",  {16'd0, m_out_data},  32'd0);
    check("arst_stall_cnt", {28'd0, m_stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    fired = 0;
    drive_src();
    out_ready = 1'b1;
    repeat (3) tick();
    check("arst_nothing_out", fired, 32'd0);

    // ---------------- SKID=0: streaming
    sel = 1'b0;
    do_reset();
    out_ready = 1'b1;
    load_stream(8);
    repeat (9) tick();
    check("s0_stream_fired", fired, 32'd8);

    // ---------------- SKID=0: stall stimulus
    do_reset();
    out_ready = 1'b1;
    load_stream(3);
    tick();                    // accept 1
    out_ready = 1'b0;
    #1;
    check("s0_in_ready_comb_low", {31'd0, m_in_ready}, 32'd0);
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    #1;
    check("s0_in_ready_comb_high", {31'd0, m_in_ready}, 32'd1);
    tick();
    tick();
    tick();
    check("s0_fired", fired, 32'd3);
    check("s0_left",  exp_q.size(), 32'd0);
    check("s0_cnt",   {28'd0, m_stall_cnt}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
